// File: rtl/io_keysw_ctrl_if.sv
// Processor-side register bus of io_keysw_ctrl: address/data/strobes in,
// combinational read data, address-hit and registered interrupt out.
interface io_keysw_ctrl_if #(
  parameter int DBITS = 32
) ();
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wrdata;
  logic [DBITS-1:0] rddata;
  logic             we;
  logic             re;
  logic             sel;
  logic             irq;

  modport master (output addr, wrdata, we, re, input rddata, sel, irq);
  modport slave  (input addr, wrdata, we, re, output rddata, sel, irq);
endinterface

// File: rtl/io_keysw_ctrl.sv
// Pushbutton/slide-switch device: 2-flop sync + per-bit debounce, KDATA/KCTRL/SDATA/SCTRL
// registers with Ready/Overrun/IE, combinational read data, registered interrupt.
module io_keysw_ctrl #(
  parameter int               DBITS     = 32,
  parameter int               DEBCYC    = 500000,
  parameter logic [DBITS-1:0] ADDRKDATA = 32'hFFFFF080,
  parameter logic [DBITS-1:0] ADDRKCTRL = 32'hFFFFF084,
  parameter logic [DBITS-1:0] ADDRSDATA = 32'hFFFFF090,
  parameter logic [DBITS-1:0] ADDRSCTRL = 32'hFFFFF094
) (
  input  logic           clk,
  input  logic           RESET_N,
  input  logic [3:0]     KEY,
  input  logic [9:0]     SW,
  io_keysw_ctrl_if.slave bus
);
  localparam int NB = 14;
  localparam int CW = $clog2(DEBCYC);

  // Bits [3:0] are keys in pressed-high form, bits [13:4] are switches.
  logic [NB-1:0] raw, sync1, sync2, deb, deb_nxt;
  logic [CW-1:0] cnt [NB];
  logic [CW-1:0] cnt_nxt [NB];

  assign raw = {SW, ~KEY};

  always_comb begin
    deb_nxt = deb;
    for (int i = 0; i < NB; i++) begin
      cnt_nxt[i] = '0;
    end
    for (int i = 0; i < NB; i++) begin
      if (sync2[i] != deb[i]) begin
        if (cnt[i] == CW'(DEBCYC - 1)) begin
          deb_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb   <= deb_nxt;
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // Status vectors: index 0 is the key device, index 1 the switch device.
  logic       hit_kd, hit_kc, hit_sd, hit_sc;
  logic       rd;
  logic [1:0] evt, rd_dat, wr_ctl, ovr_set, ovr_clr;
  logic [1:0] rdy, ovr, ie;
  logic       irq_q;

  assign hit_kd = (bus.addr == ADDRKDATA);
  assign hit_kc = (bus.addr == ADDRKCTRL);
  assign hit_sd = (bus.addr == ADDRSDATA);
  assign hit_sc = (bus.addr == ADDRSCTRL);
  assign bus.sel = hit_kd | hit_kc | hit_sd | hit_sc;

  // A simultaneous write wins over a read.
  assign rd      = bus.re & ~bus.we;
  assign evt     = {|(deb_nxt[13:4] ^ deb[13:4]), |(deb_nxt[3:0] ^ deb[3:0])};
  assign rd_dat  = {rd & hit_sd, rd & hit_kd};
  assign wr_ctl  = {bus.we & hit_sc, bus.we & hit_kc};
  assign ovr_set = evt & rdy & ~rd_dat;
  assign ovr_clr = wr_ctl & {2{~bus.wrdata[2]}};

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      rdy   <= '0;
      ovr   <= '0;
      ie    <= '0;
      irq_q <= 1'b0;
    end else begin
      rdy   <= evt | (rdy & ~rd_dat);
      ovr   <= ovr_set | (ovr & ~ovr_clr);
      ie    <= (wr_ctl & {2{bus.wrdata[8]}}) | (ie & ~wr_ctl);
      irq_q <= |(ie & rdy);
    end
  end

  assign bus.irq = irq_q;

  logic [DBITS-1:0] rdat;

  always_comb begin
    rdat = '0;
    if (rd) begin
      if (hit_kd) rdat[3:0] = deb[3:0];
      if (hit_sd) rdat[9:0] = deb[13:4];
      if (hit_kc) begin
        rdat[0] = rdy[0];
        rdat[2] = ovr[0];
        rdat[8] = ie[0];
      end
      if (hit_sc) begin
        rdat[0] = rdy[1];
        rdat[2] = ovr[1];
        rdat[8] = ie[1];
      end
    end
  end

  assign bus.rddata = rdat;

  logic unused_wrdata;
  assign unused_wrdata = ^{bus.wrdata[DBITS-1:9], bus.wrdata[7:3], bus.wrdata[1:0]};
endmodule

// File: tb/tb_io_keysw_ctrl.sv
// Directed and randomized bench for io_keysw_ctrl, checked against a
// sample-window reference model of synchronize/debounce/status behaviour.
module tb_io_keysw_ctrl;
  localparam int DEBCYC = 4;
  localparam logic [31:0] AKD = 32'hFFFFF080;
  localparam logic [31:0] AKC = 32'hFFFFF084;
  localparam logic [31:0] ASD = 32'hFFFFF090;
  localparam logic [31:0] ASC = 32'hFFFFF094;

  logic       clk = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] KEY = 4'hF;
  logic [9:0] SW = '0;
  int         tests = 0;
  int         fails = 0;
  int         op;
  logic [31:0] a;
  logic [31:0] regs [4] = '{AKD, AKC, ASD, ASC};

  io_keysw_ctrl_if #(.DBITS(32)) bus ();

  io_keysw_ctrl #(.DBITS(32), .DEBCYC(DEBCYC)) dut (
    .clk(clk), .RESET_N(RESET_N), .KEY(KEY), .SW(SW), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference state: recent raw samples, window of synchronized samples,
  // debounced levels and per-device status (0 = keys, 1 = switches).
  logic [13:0] raw_q [$];
  logic [13:0] syn_q [$];
  logic [13:0] m_deb = '0;
  logic [1:0]  m_rdy = '0, m_ovr = '0, m_ie = '0;
  logic        m_irq = 1'b0;

  task automatic model_step();
    logic [13:0] syn, nd;
    logic [1:0]  evt, rdd, wrc;
    logic        rd, all_diff;
    if (!RESET_N) begin
      raw_q.delete(); syn_q.delete();
      m_deb = '0; m_rdy = '0; m_ovr = '0; m_ie = '0; m_irq = 1'b0;
      return;
    end
    syn = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 14'h0;
    raw_q.push_back({SW, ~KEY});
    if (raw_q.size() > 2) void'(raw_q.pop_front());
    syn_q.push_back(syn);
    if (syn_q.size() > DEBCYC) void'(syn_q.pop_front());
    nd = m_deb;
    if (syn_q.size() == DEBCYC) begin
      for (int i = 0; i < 14; i++) begin
        all_diff = 1'b1;
        foreach (syn_q[j]) if (syn_q[j][i] == m_deb[i]) all_diff = 1'b0;
        if (all_diff) nd[i] = ~m_deb[i];
      end
    end
    evt[0] = |(nd[3:0] ^ m_deb[3:0]);
    evt[1] = |(nd[13:4] ^ m_deb[13:4]);
    rd  = bus.re && !bus.we;
    rdd = {rd && bus.addr == ASD, rd && bus.addr == AKD};
    wrc = {bus.we && bus.addr == ASC, bus.we && bus.addr == AKC};
    m_irq = |(m_ie & m_rdy);
    for (int d = 0; d < 2; d++) begin
      if (evt[d] && m_rdy[d] && !rdd[d]) m_ovr[d] = 1'b1;
      else if (wrc[d] && !bus.wrdata[2]) m_ovr[d] = 1'b0;
      if (evt[d]) m_rdy[d] = 1'b1;
      else if (rdd[d]) m_rdy[d] = 1'b0;
      if (wrc[d]) m_ie[d] = bus.wrdata[8];
    end
    m_deb = nd;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] ad);
    case (ad)
      AKD:     return {28'h0, m_deb[3:0]};
      ASD:     return {22'h0, m_deb[13:4]};
      AKC:     return {23'h0, m_ie[0], 5'h0, m_ovr[0], 1'b0, m_rdy[0]};
      ASC:     return {23'h0, m_ie[1], 5'h0, m_ovr[1], 1'b0, m_rdy[1]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_sel(input logic [31:0] ad);
    return (ad == AKD) || (ad == AKC) || (ad == ASD) || (ad == ASC);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("irq", {31'h0, bus.irq}, {31'h0, m_irq});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [31:0] ad, input logic w, input logic r, input logic [31:0] d);
    bus.addr = ad; bus.we = w; bus.re = r; bus.wrdata = d;
  endtask

  task automatic rd_exp(input string tag, input logic [31:0] ad, input logic [31:0] exp);
    drive(ad, 1'b0, 1'b1, 32'h0);
    #1;
    chk(tag, bus.rddata, exp);
    chk({tag, "_mdl"}, bus.rddata, m_read(ad));
    chk({tag, "_sel"}, {31'h0, bus.sel}, 32'h1);
    tick();
    drive(32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] ad, input logic [31:0] d);
    drive(ad, 1'b1, 1'b0, d);
    tick();
    drive(32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    drive(32'h0, 1'b0, 1'b0, 32'h0);
    ticks(3);
    RESET_N = 1'b1;

    // Reset state and unmapped accesses
    rd_exp("rst_kdata", AKD, 32'h0);
    rd_exp("rst_kctrl", AKC, 32'h0);
    rd_exp("rst_sdata", ASD, 32'h0);
    rd_exp("rst_sctrl", ASC, 32'h0);
    drive(32'hFFFFF088, 1'b1, 1'b0, 32'h104);
    tick();
    drive(32'hFFFFF088, 1'b0, 1'b1, 32'h0);
    #1;
    chk("unmap_sel", {31'h0, bus.sel}, 32'h0);
    chk("unmap_rd", bus.rddata, 32'h0);
    tick();
    rd_exp("unmap_kctrl", AKC, 32'h0);

    // Key press, read clears Ready
    KEY = 4'b1101;
    ticks(7);
    rd_exp("k1_kctrl", AKC, 32'h1);
    rd_exp("k1_kdata", AKD, 32'h2);
    rd_exp("k1_clr", AKC, 32'h0);
    KEY = 4'hF;
    ticks(7);
    rd_exp("k1_rel_kdata", AKD, 32'h0);
    rd_exp("k1_rel_kctrl", AKC, 32'h0);

    // Short glitch rejected
    KEY = 4'b1110;
    ticks(3);
    KEY = 4'hF;
    ticks(8);
    rd_exp("glitch_kctrl", AKC, 32'h0);
    rd_exp("glitch_kdata", AKD, 32'h0);

    // Overrun on switches, write-0-to-clear, ignored writes
    SW = 10'h3FF;
    ticks(7);
    SW = 10'h001;
    ticks(7);
    rd_exp("sw_sctrl_ovr", ASC, 32'h5);
    wr(ASC, 32'h4);
    rd_exp("sw_w1_ovr", ASC, 32'h5);
    wr(ASD, 32'h0);
    rd_exp("sw_wdata_ign", ASC, 32'h5);
    wr(ASC, 32'h0);
    rd_exp("sw_ovr_clr", ASC, 32'h1);
    rd_exp("sw_sdata", ASD, 32'h1);
    rd_exp("sw_rdy_clr", ASC, 32'h0);

    // Interrupt timing
    wr(AKC, 32'h100);
    KEY = 4'b1011;
    ticks(6);
    drive(AKC, 1'b0, 1'b1, 32'h0);
    #1;
    chk("irq_kctrl", bus.rddata, 32'h101);
    chk("irq_pre", {31'h0, bus.irq}, 32'h0);
    tick();
    chk("irq_set", {31'h0, bus.irq}, 32'h1);
    drive(AKD, 1'b0, 1'b1, 32'h0);
    #1;
    chk("irq_kdata", bus.rddata, 32'h4);
    tick();
    drive(32'h0, 1'b0, 1'b0, 32'h0);
    chk("irq_hold", {31'h0, bus.irq}, 32'h1);
    tick();
    chk("irq_drop", {31'h0, bus.irq}, 32'h0);
    KEY = 4'hF;
    ticks(7);
    rd_exp("irq_rel_kdata", AKD, 32'h0);
    wr(AKC, 32'h0);
    ticks(2);

    // Data read coincident with a change event
    KEY = 4'b1110;
    ticks(7);
    KEY = 4'b0110;
    ticks(5);
    drive(AKD, 1'b0, 1'b1, 32'h0);
    #1;
    chk("coin_kdata", bus.rddata, 32'h1);
    tick();
    drive(32'h0, 1'b0, 1'b0, 32'h0);
    rd_exp("coin_kctrl", AKC, 32'h1);
    rd_exp("coin_kdata2", AKD, 32'h9);
    rd_exp("coin_clr", AKC, 32'h0);
    KEY = 4'hF;
    ticks(7);
    rd_exp("coin_rel_kdata", AKD, 32'h0);
    rd_exp("coin_rel_kctrl", AKC, 32'h0);

    // Reset mid-debounce; switch high at release
    RESET_N = 1'b0;
    SW = 10'h000;
    ticks(2);
    RESET_N = 1'b1;
    ticks(2);
    SW = 10'h010;
    ticks(3);
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    rd_exp("mid_sctrl0", ASC, 32'h0);
    rd_exp("mid_kctrl0", AKC, 32'h0);
    rd_exp("mid_sdata0", ASD, 32'h0);
    tick();
    rd_exp("mid_sctrl_wait", ASC, 32'h0);
    tick();
    rd_exp("mid_sctrl_evt", ASC, 32'h1);
    drive(ASD, 1'b1, 1'b1, 32'h0);
    tick();
    drive(32'h0, 1'b0, 1'b0, 32'h0);
    rd_exp("wr_rd_keeps_rdy", ASC, 32'h1);
    rd_exp("mid_sdata", ASD, 32'h10);
    rd_exp("mid_sctrl_clr", ASC, 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) KEY = KEY ^ 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) SW = SW ^ 10'($urandom_range(0, 1023));
      op = $urandom_range(0, 9);
      a = regs[$urandom_range(0, 3)];
      case (op)
        0, 1, 2: drive(a, 1'b0, 1'b1, 32'h0);
        3:       drive(a, 1'b1, 1'b0, 32'($urandom));
        4:       drive(a, 1'b1, 1'b1, 32'($urandom));
        5:       drive(32'hFFFFF000 | 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, 32'($urandom));
        default: drive(a, 1'b0, 1'b0, 32'($urandom));
      endcase
      #1;
      chk("rnd_rddata", bus.rddata, (bus.re && !bus.we) ? m_read(bus.addr) : 32'h0);
      chk("rnd_sel", {31'h0, bus.sel}, {31'h0, m_sel(bus.addr)});
      tick();
    end
    drive(32'h0, 1'b0, 1'b0, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/io_keysw_ctrl.md
IO_KEYSW_CTRL -- requirements
Module: io_keysw_ctrl

Interface
REQ-001 Parameter DBITS, default 32, data bus width.
REQ-002 Parameter DEBCYC, default 500000, consecutive stable cycles required to accept a new input level (>=2).
REQ-003 Parameter ADDRKDATA/ADDRKCTRL/ADDRSDATA/ADDRSCTRL, defaults 32'hFFFFF080/32'hFFFFF084/32'hFFFFF090/32'hFFFFF094.
REQ-004 clk  input  1  processor clock; all state updates on rising edge only.
REQ-005 RESET_N  input  1  synchronous, active-low reset.
REQ-006 KEY  input  4  raw pushbuttons, active-low, asynchronous to clk.
REQ-007 SW  input  10  raw slide switches, active-high, asynchronous to clk.
REQ-008 addr  input  DBITS  processor MAR value.
REQ-009 wrdata  input  DBITS  processor bus value during a write.
REQ-010 we  input  1  write strobe (processor WrMem), one cycle per access.
REQ-011 re  input  1  read strobe (processor DrMem), one cycle per access.
REQ-012 rddata  output  DBITS  combinational read data for the addressed register.
REQ-013 sel  output  1  high when addr equals any of the four register addresses.
REQ-014 irq  output  1  registered; high when any enabled Ready bit is set.

Function
REQ-015 Each KEY and SW bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-016 Each bit SHALL own a debounce counter; the debounced level changes only after the synchronized level differs from it for DEBCYC consecutive cycles; any return to the debounced level clears the counter.
REQ-017 The debounced key vector SHALL be stored pressed-high (inverted KEY).
REQ-018 KDATA read SHALL return {28'b0, debounced pressed keys}; SDATA read SHALL return {22'b0, debounced SW}.
REQ-019 KCTRL/SCTRL layout: bit0 Ready (read-only), bit2 Overrun (write-0-to-clear), bit8 IE (read/write); other bits read 0, writes ignored.
REQ-020 A change event is any cycle in which at least one debounced bit of a device toggles; it SHALL set Ready the following cycle.
REQ-021 A change event while Ready is already 1 SHALL also set Overrun.
REQ-022 re with addr==KDATA (SDATA) SHALL clear that device's Ready at the clock edge; rddata is valid in the same cycle.
REQ-023 Simultaneous data read and change event: Ready stays 1, Overrun unchanged.
REQ-024 Simultaneous Overrun write-0 and new overrun condition: Overrun stays 1.
REQ-025 Writing 1 to Overrun or any value to Ready SHALL have no effect; writes to KDATA/SDATA SHALL be ignored.
REQ-026 re or we with sel low SHALL change no state; rddata SHALL be 0 when sel low or re low.
REQ-027 irq SHALL equal (KCTRL.IE & KCTRL.Ready) | (SCTRL.IE & SCTRL.Ready), registered one cycle.
REQ-028 we and re asserted together SHALL be treated as write only.

Reset
REQ-029 While RESET_N is low at a clock edge: Ready, Overrun, IE, irq, counters, synchronizers cleared; debounced KEY = 0 (none pressed); debounced SW = 0.
REQ-030 A switch already high at reset release SHALL generate exactly one change event after DEBCYC+2 cycles.
REQ-031 Reset asserted mid-debounce SHALL discard the partial count with no event after release unless the input remains changed DEBCYC cycles.

Verification (DEBCYC=4)
REQ-032 KEY[1] driven low, held -> KDATA=32'h2 and KCTRL Ready=1 within DEBCYC+3 cycles; read KDATA -> Ready=0 next cycle.
REQ-033 KEY[0] glitch low for 3 cycles then high -> no change event, KDATA=0, Ready=0.
REQ-034 SW set 10'h3FF, then 10'h001 without reading -> SDATA=32'h1, SCTRL=32'h5; write SCTRL=32'h0 -> SCTRL=32'h1.
REQ-035 KCTRL written 32'h100, key press -> irq=1 one cycle after Ready; KDATA read -> irq=0 two cycles later.
REQ-036 Read KDATA on the same cycle as a new change event -> Ready stays 1, Overrun 0.
REQ-037 RESET_N low for one cycle during an 8-cycle switch hold -> all status 0, event only after a fresh full DEBCYC window.
